// File: rtl/adc_pixel_capture.sv
// adc_pixel_capture
//   Captures pixels from an ADC front end. It tags each pixel with its x/y
//   position and converts it to rgb565. Pixels are queued in a show-ahead
//   FIFO that an SRAM writer drains.
//   Optional feature macro: ADC_CAPTURE_STATS_EN adds the drop_count port,
//   which counts pixels lost to a full FIFO.
//
// Handshake: pixel_ready is high whenever the FIFO holds an entry, and
// pixel_data then shows the head entry. A cycle with pixel_read and
// pixel_ready both high consumes the head. pixel_read while pixel_ready is
// low has no effect. The ADC side has no back-pressure: adc_valid marks one
// pixel per cycle, and that pixel is either stored, ignored or dropped.
module adc_pixel_capture #(
    parameter int X_RES      = 800,
    parameter int Y_RES      = 600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        adc_valid,
    input  logic        adc_hsync,
    input  logic        adc_vsync,
    input  logic [7:0]  adc_r,
    input  logic [7:0]  adc_g,
    input  logic [7:0]  adc_b,
    output logic [37:0] pixel_data,
    output logic        pixel_ready,
    input  logic        pixel_read,
`ifdef ADC_CAPTURE_STATS_EN
    output logic [15:0] drop_count,
`endif
    output logic [0:0]  dbg_state_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FRAME = 1'b1;

    localparam logic [10:0] COORD_MAX = 11'h7FF;

    logic [0:0]  state_q, state_d;
    logic [10:0] x_q, x_d;
    logic [10:0] y_q, y_d;
    logic        seen_q, seen_d;
    logic        vs_prev_q, hs_prev_q;
    logic        vs_rise, hs_rise;
    logic        push_req;
    logic [15:0] rgb565;

    logic [37:0] mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        fifo_empty, fifo_full;
    logic        do_push, do_pop;

    assign vs_rise = adc_vsync & ~vs_prev_q;
    assign hs_rise = adc_hsync & ~hs_prev_q;
    assign rgb565  = {adc_r[7:3], adc_g[7:2], adc_b[7:3]};

    assign dbg_state_o = state_q;

    // Remember the previous sync levels so that rising edges can be detected
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_prev_q <= 1'b0;
            hs_prev_q <= 1'b0;
        end else begin
            vs_prev_q <= adc_vsync;
            hs_prev_q <= adc_hsync;
        end
    end

    // Capture state machine and coordinates. A sync edge wins over a
    // coincident pixel, and that pixel is discarded.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        seen_d   = seen_q;
        push_req = 1'b0;
        if (vs_rise) begin
            state_d = ST_FRAME;
            x_d     = 11'd0;
            y_d     = 11'd0;
            seen_d  = 1'b0;
        end else if (state_q == ST_FRAME) begin
            if (hs_rise) begin
                x_d    = 11'd0;
                seen_d = 1'b0;
                // A line only advances y if it carried at least one pixel
                if (seen_q && (y_q != COORD_MAX)) begin
                    y_d = y_q + 11'd1;
                end
            end else if (adc_valid) begin
                push_req = (int'(x_q) < X_RES) && (int'(y_q) < Y_RES);
                seen_d   = 1'b1;
                if (x_q != COORD_MAX) begin
                    x_d = x_q + 11'd1;
                end
            end
        end
    end

    // Capture state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            x_q     <= 11'd0;
            y_q     <= 11'd0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            seen_q  <= seen_d;
        end
    end

    // FIFO status. The extra pointer bit separates the full case from the empty case.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop     = pixel_read & ~fifo_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign do_push    = push_req & (~fifo_full | do_pop);

    assign pixel_ready = ~fifo_empty;
    assign pixel_data  = fifo_empty ? 38'd0 : mem_q[rd_ptr_q[AW-1:0]];

    // FIFO storage. It needs no reset because the output is gated by empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {x_q, y_q, rgb565};
        end
    end

    // FIFO pointers. They wrap naturally modulo 2*FIFO_DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

`ifdef ADC_CAPTURE_STATS_EN
    logic [15:0] drop_q;
    logic        drop_event;

    assign drop_event = push_req & fifo_full & ~do_pop;
    assign drop_count = drop_q;

    // Saturating count of in-range pixels lost to a full FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= 16'd0;
        end else if (drop_event && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_adc_pixel_capture.sv
// Testbench for adc_pixel_capture. Build with +define+ADC_CAPTURE_STATS_EN
// to also check drop_count.
module tb_adc_pixel_capture;

  localparam int X_RES = 800;
  localparam int Y_RES = 600;
  localparam int DEPTH = 16;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        adc_valid = 1'b0;
  logic        adc_hsync = 1'b0;
  logic        adc_vsync = 1'b0;
  logic [7:0]  adc_r = 8'd0;
  logic [7:0]  adc_g = 8'd0;
  logic [7:0]  adc_b = 8'd0;
  logic [37:0] pixel_data;
  logic        pixel_ready;
  logic        pixel_read = 1'b0;
  logic [0:0]  dbg_state_o;
`ifdef ADC_CAPTURE_STATS_EN
  logic [15:0] drop_count;
`endif

  always #5 clk = ~clk;

  adc_pixel_capture #(.X_RES(X_RES), .Y_RES(Y_RES), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .adc_valid   (adc_valid),
    .adc_hsync   (adc_hsync),
    .adc_vsync   (adc_vsync),
    .adc_r       (adc_r),
    .adc_g       (adc_g),
    .adc_b       (adc_b),
    .pixel_data  (pixel_data),
    .pixel_ready (pixel_ready),
    .pixel_read  (pixel_read),
`ifdef ADC_CAPTURE_STATS_EN
    .drop_count  (drop_count),
`endif
    .dbg_state_o (dbg_state_o)
  );

  // ---------------- scoreboard / reference model ----------------
  int          n_checks = 0;
  int          n_fail = 0;
  logic [37:0] exp_q[$];     // expected FIFO contents, head at index 0
  logic [37:0] pop_log[$];   // entries the DUT handed over on a read
  bit          m_frame, m_seen, m_vs_prev, m_hs_prev;
  int          m_x, m_y, m_drops;
  logic [37:0] exp_head;

  function automatic logic [37:0] pack(input int x, input int y,
                                       input logic [7:0] r, g, b);
    int rgb;
    rgb = ((int'(r) / 8) * 2048) + ((int'(g) / 4) * 32) + (int'(b) / 8);
    return (38'(x) << 27) | (38'(y) << 16) | 38'(rgb);
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_frame = 0; m_seen = 0; m_vs_prev = 0; m_hs_prev = 0;
    m_x = 0; m_y = 0; m_drops = 0;
  endfunction

  function automatic void model_update(input bit v, hs, vs,
                                       input logic [7:0] r, g, b, input bit rd);
    bit          vr, hr, pop, push;
    logic [37:0] ent;
    vr = vs && !m_vs_prev;
    hr = hs && !m_hs_prev;
    pop = rd && (exp_q.size() > 0);
    push = 0;
    ent = '0;
    m_vs_prev = vs;
    m_hs_prev = hs;
    if (vr) begin
      m_frame = 1; m_x = 0; m_y = 0; m_seen = 0;
    end else if (m_frame && hr) begin
      if (m_seen) m_y = (m_y < 2047) ? m_y + 1 : 2047;
      m_x = 0;
      m_seen = 0;
    end else if (m_frame && v) begin
      if (m_x < X_RES && m_y < Y_RES) begin
        push = 1;
        ent = pack(m_x, m_y, r, g, b);
      end
      m_x = (m_x < 2047) ? m_x + 1 : 2047;
      m_seen = 1;
    end
    if (pop) void'(exp_q.pop_front());
    if (push) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(ent);
      else if (m_drops < 65535) m_drops++;
    end
    exp_head = (exp_q.size() > 0) ? exp_q[0] : 38'd0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input bit v, hs, vs, input logic [7:0] r, g, b, input bit rd);
    @(negedge clk);
    adc_valid = v; adc_hsync = hs; adc_vsync = vs;
    adc_r = r; adc_g = g; adc_b = b; pixel_read = rd;
    #1;
    if (rd && pixel_ready) pop_log.push_back(pixel_data);
    @(posedge clk);
    model_update(v, hs, vs, r, g, b, rd);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    adc_valid = 0; adc_hsync = 0; adc_vsync = 0; pixel_read = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle_pixel(input bit rd);
    step(1'b1, 1'b0, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom), rd);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (pixel_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got %0b want 0", pixel_ready);
    end
    n_checks++;
    if (pixel_data !== 38'd0) begin
      n_fail++; $display("FAIL reset_data: got %h want 0", pixel_data);
    end
    n_checks++;
    if (dbg_state_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_state: got %0b want 0", dbg_state_o);
    end
`ifdef ADC_CAPTURE_STATS_EN
    n_checks++;
    if (drop_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_drops: got %0d want 0", drop_count);
    end
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_idle_discard();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle_pixel(1'b0);
      n_checks++;
      if (pixel_ready !== 1'b0 || dbg_state_o !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_discard px%0d: ready=%0b state=%0b want 0/0", i, pixel_ready, dbg_state_o);
      end
    end
    step(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 1'b0);
    n_checks++;
    if (pixel_ready !== 1'b0 || dbg_state_o !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_vsync: ready=%0b state=%0b want 0/1", pixel_ready, dbg_state_o);
    end
  endtask

  task automatic test_rgb565();
    do_reset();
    step(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'hFF, 8'h80, 8'h07, 1'b0);
    n_checks++;
    if (pixel_ready !== 1'b1 || pixel_data !== 38'h00_0000_FC00) begin
      n_fail++;
      $display("FAIL rgb565: ready=%0b data=%h want 1/%h", pixel_ready, pixel_data, 38'h00_0000_FC00);
    end
    n_checks++;
    if (pixel_data !== exp_head) begin
      n_fail++; $display("FAIL rgb565_model: got %h want %h", pixel_data, exp_head);
    end
  endtask

  task automatic test_line_wrap();
    int bad_x;
    do_reset();
    pop_log.delete();
    step(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 1'b1);
    for (int i = 0; i < 804; i++) begin
      if (i < 802)       idle_pixel(1'b1);
      else if (i == 802) step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
      else               idle_pixel(1'b1);
      n_checks++;
      if (pixel_ready !== (exp_q.size() != 0) || pixel_data !== exp_head) begin
        n_fail++;
        $display("FAIL line_stream cyc%0d: ready=%0b data=%h want %0b/%h", i, pixel_ready, pixel_data, exp_q.size() != 0, exp_head);
      end
    end
    for (int i = 0; i < 20 && pixel_ready === 1'b1; i++)
      step(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
    n_checks++;
    if (pop_log.size() != 801) begin
      n_fail++; $display("FAIL line_count: got %0d entries want 801", pop_log.size());
    end else begin
      bad_x = 0;
      for (int i = 0; i < 800; i++)
        if (pop_log[i][37:27] !== 11'(i) || pop_log[i][26:16] !== 11'd0) bad_x++;
      n_checks++;
      if (bad_x != 0) begin
        n_fail++; $display("FAIL line_tags: %0d bad entries want 0", bad_x);
      end
      n_checks++;
      if (pop_log[800][37:27] !== 11'd0 || pop_log[800][26:16] !== 11'd1) begin
        n_fail++;
        $display("FAIL line_next: x=%0d y=%0d want x=0 y=1", pop_log[800][37:27], pop_log[800][26:16]);
      end
    end
  endtask

  task automatic test_full_drop();
    do_reset();
    step(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 1'b0);
    for (int i = 0; i < 21; i++) begin
      idle_pixel(1'b0);
      n_checks++;
      if (pixel_ready !== 1'b1 || pixel_data !== exp_head) begin
        n_fail++;
        $display("FAIL full_fill px%0d: ready=%0b data=%h want 1/%h", i, pixel_ready, pixel_data, exp_head);
      end
    end
    n_checks++;
    if (pixel_data[37:16] !== 22'd0) begin
      n_fail++; $display("FAIL full_head: xy=%h want 0", pixel_data[37:16]);
    end
`ifdef ADC_CAPTURE_STATS_EN
    n_checks++;
    if (drop_count !== 16'd5) begin
      n_fail++; $display("FAIL full_drops: got %0d want 5", drop_count);
    end
`endif
  endtask

  task automatic test_full_push_pop();
    // continues from the full FIFO left by test_full_drop
    pop_log.delete();
    idle_pixel(1'b1);
    n_checks++;
    if (pixel_ready !== 1'b1 || pixel_data[37:27] !== 11'd1 || pixel_data !== exp_head) begin
      n_fail++;
      $display("FAIL pushpop_head: ready=%0b data=%h want x=1 %h", pixel_ready, pixel_data, exp_head);
    end
`ifdef ADC_CAPTURE_STATS_EN
    n_checks++;
    if (drop_count !== 16'd5) begin
      n_fail++; $display("FAIL pushpop_drops: got %0d want 5", drop_count);
    end
`endif
    pop_log.delete();
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
    n_checks++;
    if (pop_log.size() != 16 || pixel_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL pushpop_drain: popped %0d ready=%0b want 16/0", pop_log.size(), pixel_ready);
    end else begin
      n_checks++;
      if (pop_log[15][37:27] !== 11'd21) begin
        n_fail++; $display("FAIL pushpop_last: x=%0d want 21", pop_log[15][37:27]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    step(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 1'b0);
    for (int i = 0; i < 7; i++) idle_pixel(1'b0);
    n_checks++;
    if (pixel_ready !== 1'b1) begin
      n_fail++; $display("FAIL midrst_prefill: ready=%0b want 1", pixel_ready);
    end
    @(negedge clk);
    rst_n = 1'b0;
    adc_valid = 0; adc_vsync = 0; adc_hsync = 0; pixel_read = 0;
    model_reset();
    #1;
    n_checks++;
    if (pixel_ready !== 1'b0 || pixel_data !== 38'd0) begin
      n_fail++; $display("FAIL midrst_async: ready=%0b data=%h want 0/0", pixel_ready, pixel_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle_pixel(1'b0);
      n_checks++;
      if (pixel_ready !== 1'b0) begin
        n_fail++; $display("FAIL midrst_ignore px%0d: ready=%0b want 0", i, pixel_ready);
      end
    end
    step(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 1'b0);
    idle_pixel(1'b0);
    n_checks++;
    if (pixel_ready !== 1'b1 || pixel_data[37:16] !== 22'd0 || pixel_data !== exp_head) begin
      n_fail++;
      $display("FAIL midrst_resume: ready=%0b data=%h want 1/%h", pixel_ready, pixel_data, exp_head);
    end
  endtask

  task automatic test_random();
    bit v, hs, vs, rd;
    do_reset();
    step(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      v  = ($urandom_range(0, 9) < 7);
      hs = ($urandom_range(0, 39) == 0);
      vs = ($urandom_range(0, 299) == 0);
      rd = ($urandom_range(0, 9) < 6);
      step(v, hs, vs, 8'($urandom), 8'($urandom), 8'($urandom), rd);
      n_checks++;
      if (pixel_ready !== (exp_q.size() != 0) || pixel_data !== exp_head ||
          dbg_state_o !== 1'(m_frame)) begin
        n_fail++;
        $display("FAIL random cyc%0d: ready=%0b data=%h st=%0b want %0b/%h/%0b", i, pixel_ready, pixel_data, dbg_state_o, exp_q.size() != 0, exp_head, m_frame);
      end
`ifdef ADC_CAPTURE_STATS_EN
      n_checks++;
      if (drop_count !== 16'(m_drops)) begin
        n_fail++; $display("FAIL random_drops cyc%0d: got %0d want %0d", i, drop_count, m_drops);
      end
`endif
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    model_reset();
    exp_head = '0;
    test_reset();
    test_idle_discard();
    test_rgb565();
    test_line_wrap();
    test_full_drop();
    test_full_push_pop();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_pixel_capture.md
ADC_PIXEL_CAPTURE -- requirements
Module: adc_pixel_capture

Interface
REQ-001 The block SHALL have parameter X_RES, default 800, meaning the active width in pixels.
REQ-002 The block SHALL have parameter Y_RES, default 600, meaning the active height in lines.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 16, meaning the number of output FIFO entries (power of two).
REQ-004 Port clk  input  1  is the single clock; all logic is on its rising edge.
REQ-005 Port rst_n  input  1  is the reset; reset is asynchronous, active-low.
REQ-006 Port adc_valid  input  1  is the pixel strobe from the ADC front end, one pixel per asserted cycle.
REQ-007 Ports adc_hsync and adc_vsync  input  1 each  are active-high syncs from the ADC.
REQ-008 Ports adc_r, adc_g and adc_b  input  8 each  are the pixel colour.
REQ-009 Port pixel_data  output  38  SHALL be the FIFO head: {x[10:0], y[10:0], rgb565[15:0]}.
REQ-010 Port pixel_ready  output  1  SHALL be high when the FIFO is non-empty.
REQ-011 Port pixel_read  input  1  is a consume pulse from the SRAM writer.
REQ-012 Port drop_count  output  16  SHALL count pixels lost to a full FIFO (present only under ADC_CAPTURE_STATS_EN).

Function
REQ-013 State IDLE SHALL be entered on reset; all input pixels are discarded until a vsync rising edge.
REQ-014 A vsync rising edge (in any state) SHALL set x=0, y=0 and enter state FRAME.
REQ-015 In FRAME, an hsync rising edge SHALL set x=0 and, if at least one adc_valid occurred since the last sync, increment y.
REQ-016 y SHALL saturate at 2047; x SHALL increment per adc_valid in FRAME and saturate at 2047.
REQ-017 A sync edge coinciding with adc_valid SHALL take priority; that pixel is discarded and the counters are not advanced.
REQ-018 rgb565 SHALL be {r[7:3], g[7:2], b[7:3]}, pure truncation with no rounding.
REQ-019 A pixel SHALL be pushed only in FRAME with x<X_RES and y<Y_RES, tagged with its pre-increment x and y.
REQ-020 Out-of-range pixels SHALL be dropped silently and SHALL NOT count as drops.
REQ-021 FIFO latency: a pixel pushed on cycle N into an empty FIFO SHALL appear on pixel_data with pixel_ready high at cycle N+1 (show-ahead).
REQ-022 pixel_read with pixel_ready high SHALL pop the head; the next entry (or ready low) is visible the following cycle.
REQ-023 pixel_read while the FIFO is empty SHALL be ignored with no pointer change.
REQ-024 A push while full SHALL be accepted if pixel_read pops on the same cycle; otherwise the pixel is dropped.
REQ-025 Pointers SHALL wrap modulo FIFO_DEPTH, using an extra bit to distinguish full from empty.

Reset
REQ-026 On rst_n low: state=IDLE, x=y=0, FIFO empty, pixel_ready=0, pixel_data=0, drop_count=0.
REQ-027 Reset mid-frame SHALL discard FIFO contents; capture resumes only after the next vsync rising edge.

Configuration
REQ-028 Macro ADC_CAPTURE_STATS_EN defined: drop_count SHALL increment on each dropped pixel (REQ-024) and saturate at 65535, clearing only on reset.
REQ-029 Macro ADC_CAPTURE_STATS_EN undefined: the drop_count port and its counter SHALL be absent, and the drop behaviour is otherwise unchanged.

Verification
REQ-030 Reset, 3 adc_valid, then vsync -> nothing pushed before the vsync; pixel_ready=0.
REQ-031 vsync, then adc_valid with r=0xFF, g=0x80, b=0x07 -> next cycle pixel_data={11'd0, 11'd0, 16'hFC00}, pixel_ready=1.
REQ-032 vsync, 802 pixels, hsync, 1 pixel -> 800 entries tagged x=0..799, y=0, then one entry with x=0, y=1; x=800 and x=801 are not pushed.
REQ-033 FIFO full (16 entries), no reads, 5 further in-range pixels -> FIFO unchanged; drop_count=5 under ADC_CAPTURE_STATS_EN.
REQ-034 FIFO full, push and pixel_read on the same cycle -> old head popped, new pixel stored, count stays 16, no drop counted.
REQ-035 rst_n pulsed low with 7 entries queued -> pixel_ready=0 immediately; pixels ignored until the next vsync.
